score_keeper: RTL and testbench
===============================

# score_keeper

Score and lives bookkeeping for the memory game. Consumes the single-cycle `inc_point` / `dec_point` verdict pulses produced by the player-input checker and turns them into a saturating 3-digit BCD score, a lives counter, a game-over flag and the `display_state` code driven to the seven-segment display controller. It runs on the fast system clock and paces its result display with a one-cycle `tick` enable derived from the display clock.

## Interface
Parameters:
- `START_LIVES`, default 3: lives loaded at reset and on `new_game`; legal range 1–7.
- `HOLD_TICKS`, default 4: number of `tick` pulses a CORRECT/WRONG result stays on `display_state`; legal range 1–15.

Ports (clock and reset first):
- `clock` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `tick` in 1: one-cycle enable at display rate; paces the hold timer.
- `new_game` in 1: one-cycle pulse that starts a game.
- `inc_point` in 1: one-cycle pulse meaning the player's answer was correct.
- `dec_point` in 1: one-cycle pulse meaning the player's answer was wrong.
- `score_bcd` out 12: score as three BCD digits, [11:8] hundreds … [3:0] units.
- `lives` out 3: remaining lives.
- `display_state` out 2: 0 = show score, 1 = CORRECT, 2 = WRONG, 3 = GAME OVER.
- `game_over` out 1: high while in OVER.
- `best_bcd` out 12: best score, BCD (see Configuration).

## Operation
- States: IDLE, PLAY, SHOW_OK, SHOW_ERR, OVER.
- `display_state` encoding by state: IDLE, PLAY → 0; SHOW_OK → 1; SHOW_ERR → 2; OVER → 3.
- **Reset** (any state, mid-operation included):
  - state IDLE, `score_bcd` 0, `lives` START_LIVES, `display_state` 0.
  - `game_over` 0, hold counter 0, `best_bcd` 0.
- **`new_game`**: from any state → PLAY.
  - `score_bcd` 0, `lives` START_LIVES, hold counter cleared.
  - Takes priority over `inc_point` / `dec_point` in the same cycle.
- **IDLE, OVER**: `inc_point` / `dec_point` are ignored.
- **PLAY, SHOW_OK, SHOW_ERR**: verdicts are accepted.
  - `inc_point` alone: score +1 in BCD (units wrap 9→0 with carry). Saturates at 999: 999 + 1 = 999. → SHOW_OK, hold counter loaded with HOLD_TICKS.
  - `dec_point` alone: lives −1. If the result is 0 → OVER. Otherwise → SHOW_ERR, hold counter loaded with HOLD_TICKS.
  - `inc_point` and `dec_point` in the same cycle: treated as `dec_point` only; the inc is discarded.
  - A verdict arriving in SHOW_OK or SHOW_ERR is applied and reloads the hold counter (retrigger).
- **Hold timer**: in SHOW_OK / SHOW_ERR, each `tick` with no verdict in that cycle decrements the counter. When it reaches 0 → PLAY.
- Score is never decremented. Lives never underflow, because OVER is entered at 0.

## Timing
- All outputs are registered. A pulse sampled at edge N is visible on `score_bcd`, `lives`, `display_state` and `game_over` after edge N.
- `tick` coincident with the accepting verdict is not counted. `display_state` returns to 0 on the edge of the HOLD_TICKS-th subsequent `tick`.
- Pulses wider than one cycle are counted once per cycle high. Upstream guarantees single-cycle pulses.
- `game_over` rises on the same edge `lives` reaches 0.

## Configuration
- Macro `SCORE_KEEPER_HIGH_SCORE_EN`.
- **Defined**: on the edge entering OVER, `best_bcd` ← `score_bcd` if the score is greater, by BCD magnitude compare.
  - `best_bcd` is kept across `new_game` and cleared only by `reset`.
  - Also on `new_game`, `best_bcd` is updated if the current score is greater; this covers abandoning a game.
- **Undefined**: `best_bcd` is a constant 12'h000 and no compare logic is built. The port list is unchanged.

## Test plan
- Reset mid-SHOW_OK with score 12'h042 → immediately `score_bcd` = 0, `lives` = 3, `display_state` = 0, `game_over` = 0, state IDLE; a following `inc_point` has no effect.
- `new_game`, then 10 `inc_point` pulses spaced 2 cycles apart → `score_bcd` 12'h010, `display_state` 1. After 4 `tick`s with no verdicts → `display_state` 0.
- Preload to 12'h099 via verdicts, then one `inc_point` → 12'h100. Preload to 12'h999, then `inc_point` → stays 12'h999.
- `new_game`, then three `dec_point`s → `lives` 2, 1, then 0 with `display_state` 3 and `game_over` 1. A further `inc_point` → unchanged.
- `inc_point` and `dec_point` in the same cycle with `lives` = 2, score 5 → score 5, `lives` 1, `display_state` 2. `new_game` coincident with `dec_point` → `lives` 3, score 0, `display_state` 0.
- With `SCORE_KEEPER_HIGH_SCORE_EN`: game 1 ends at score 7 → `best_bcd` 12'h007. Game 2 ends at score 3 → stays 12'h007. Without the macro → `best_bcd` is always 0.

Source files
------------

// File: rtl/score_keeper.sv
// Score, lives and result-display bookkeeping for the memory game.
// Optional best-score tracking is built when SCORE_KEEPER_HIGH_SCORE_EN is defined.
module score_keeper #(
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned HOLD_TICKS  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        new_game,
  input  logic        inc_point,
  input  logic        dec_point,
  output logic [11:0] score_bcd,
  output logic [2:0]  lives,
  output logic [1:0]  display_state,
  output logic        game_over,
  output logic [11:0] best_bcd
);

  localparam int unsigned SCORE_W = 12;
  localparam int unsigned LIVES_W = 3;
  localparam int unsigned HOLD_W  = 4;
  localparam int unsigned DISP_W  = 2;

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
  localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(HOLD_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = 12'h999;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_SHOW_OK,
    S_SHOW_ERR,
    S_OVER
  } state_e;

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [DISP_W-1:0]    disp_q, disp_d;
  logic                 over_q, over_d;
  logic [SCORE_W-1:0]   score_inc_c;
  logic                 take_best_c;

  // Saturating three-digit BCD increment
  always_comb begin
    score_inc_c = score_q;
    if (score_q != SCORE_MAX) begin
      if (score_q[3:0] != 4'd9) begin
        score_inc_c[3:0] = score_q[3:0] + 4'd1;
      end else begin
        score_inc_c[3:0] = 4'd0;
        if (score_q[7:4] != 4'd9) begin
          score_inc_c[7:4] = score_q[7:4] + 4'd1;
        end else begin
          score_inc_c[7:4]  = 4'd0;
          score_inc_c[11:8] = score_q[11:8] + 4'd1;
        end
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    hold_d      = hold_q;
    take_best_c = 1'b0;
    if (new_game) begin
      state_d     = S_PLAY;
      score_d     = '0;
      lives_d     = LIVES_INIT;
      hold_d      = '0;
      take_best_c = 1'b1;
    end else begin
      case (state_q)
        S_PLAY, S_SHOW_OK, S_SHOW_ERR: begin
          if (dec_point) begin
            lives_d = lives_q - LIVES_W'(1);
            if (lives_q == LIVES_W'(1)) begin
              state_d     = S_OVER;
              hold_d      = '0;
              take_best_c = 1'b1;
            end else begin
              state_d = S_SHOW_ERR;
              hold_d  = HOLD_INIT;
            end
          end else if (inc_point) begin
            score_d = score_inc_c;
            state_d = S_SHOW_OK;
            hold_d  = HOLD_INIT;
          end else if (tick && state_q != S_PLAY) begin
            if (hold_q <= HOLD_W'(1)) begin
              hold_d  = '0;
              state_d = S_PLAY;
            end else begin
              hold_d = hold_q - HOLD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end

    case (state_d)
      S_SHOW_OK:  disp_d = 2'd1;
      S_SHOW_ERR: disp_d = 2'd2;
      S_OVER:     disp_d = 2'd3;
      default:    disp_d = 2'd0;
    endcase
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      score_q <= '0;
      lives_q <= LIVES_INIT;
      hold_q  <= '0;
      disp_q  <= '0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      hold_q  <= hold_d;
      disp_q  <= disp_d;
      over_q  <= over_d;
    end
  end

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic [SCORE_W-1:0] best_q, best_d;

  // Packed BCD orders the same as the decimal value, so a plain compare suffices
  always_comb begin
    best_d = best_q;
    if (take_best_c && (score_q > best_q)) begin
      best_d = score_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      best_q <= '0;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_bcd = best_q;
`else
  logic unused_best_c;
  assign unused_best_c = take_best_c;
  assign best_bcd      = 12'h000;
`endif

  assign score_bcd     = score_q;
  assign lives         = lives_q;
  assign display_state = disp_q;
  assign game_over     = over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized
// traffic compared against an integer-valued behavioural model.
module tb_score_keeper;

  localparam int START = 3;
  localparam int HOLD  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0, new_game = 1'b0, inc_point = 1'b0, dec_point = 1'b0;
  logic [11:0] score_bcd, best_bcd;
  logic [2:0]  lives;
  logic [1:0]  display_state;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 play, 2 showing correct, 3 showing wrong, 4 over
  int m_score, m_lives, m_mode, m_hold, m_best;

  score_keeper #(.START_LIVES(START), .HOLD_TICKS(HOLD)) dut (
    .clock(clock), .reset(reset), .tick(tick), .new_game(new_game),
    .inc_point(inc_point), .dec_point(dec_point), .score_bcd(score_bcd),
    .lives(lives), .display_state(display_state), .game_over(game_over),
    .best_bcd(best_bcd)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic logic [1:0] exp_disp();
    case (m_mode)
      2: return 2'd1;
      3: return 2'd2;
      4: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic void model_reset();
    m_score = 0; m_lives = START; m_mode = 0; m_hold = 0; m_best = 0;
  endfunction

  function automatic void keep_best();
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    if (m_score > m_best) m_best = m_score;
`endif
  endfunction

  function automatic void model_step(input logic t, input logic ng, input logic ip, input logic dp);
    if (ng) begin
      keep_best();
      m_mode = 1; m_score = 0; m_lives = START; m_hold = 0;
    end else if (m_mode >= 1 && m_mode <= 3) begin
      if (dp) begin
        m_lives--;
        if (m_lives == 0) begin
          keep_best();
          m_mode = 4;
        end else begin
          m_mode = 3; m_hold = HOLD;
        end
      end else if (ip) begin
        m_score = (m_score >= 999) ? 999 : m_score + 1;
        m_mode = 2; m_hold = HOLD;
      end else if (t && m_mode != 1) begin
        m_hold--;
        if (m_hold == 0) m_mode = 1;
      end
    end
  endfunction

  task automatic step(input logic t, input logic ng, input logic ip, input logic dp);
    @(negedge clock);
    tick = t; new_game = ng; inc_point = ip; dec_point = dp;
    @(posedge clock);
    model_step(t, ng, ip, dp);
    #1;
    tick = 1'b0; new_game = 1'b0; inc_point = 1'b0; dec_point = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    step(0, 1, 0, 0);
    for (int i = 0; i < 42; i++) step(0, 0, 1, 0);
    checks++;
    if (score_bcd !== 12'h042 || display_state !== 2'd1) begin
      errors++; $display("FAIL preload42: score %h disp %0d, want 042 disp 1", score_bcd, display_state);
    end
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (score_bcd !== 12'h000 || lives !== 3'd3 || display_state !== 2'd0 || game_over !== 1'b0) begin
      errors++; $display("FAIL async_reset: score %h lives %0d disp %0d over %b, want 000 3 0 0",
                         score_bcd, lives, display_state, game_over);
    end
    @(negedge clock); reset = 1'b0;
    step(0, 0, 1, 0);
    checks++;
    if (score_bcd !== 12'h000 || display_state !== 2'd0) begin
      errors++; $display("FAIL idle_inc: score %h disp %0d, want 000 disp 0", score_bcd, display_state);
    end
  endtask

  task automatic test_hold();
    step(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    checks++;
    if (score_bcd !== 12'h010 || display_state !== 2'd1) begin
      errors++; $display("FAIL ten_incs: score %h disp %0d, want 010 disp 1", score_bcd, display_state);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    checks++;
    if (display_state !== 2'd1) begin
      errors++; $display("FAIL hold_3ticks: disp %0d, want 1", display_state);
    end
    step(1, 0, 0, 0);
    checks++;
    if (display_state !== 2'd0) begin
      errors++; $display("FAIL hold_4ticks: disp %0d, want 0", display_state);
    end
    // tick coincident with a verdict must not be counted
    step(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    checks++;
    if (display_state !== 2'd1) begin
      errors++; $display("FAIL tick_with_verdict: disp %0d, want 1", display_state);
    end
    step(1, 0, 0, 0);
  endtask

  task automatic test_bcd_carry();
    step(0, 1, 0, 0);
    for (int i = 0; i < 99; i++) step(0, 0, 1, 0);
    checks++;
    if (score_bcd !== 12'h099) begin
      errors++; $display("FAIL pre99: score %h, want 099", score_bcd);
    end
    step(0, 0, 1, 0);
    checks++;
    if (score_bcd !== 12'h100) begin
      errors++; $display("FAIL carry100: score %h, want 100", score_bcd);
    end
    for (int i = 0; i < 899; i++) step(0, 0, 1, 0);
    checks++;
    if (score_bcd !== 12'h999) begin
      errors++; $display("FAIL pre999: score %h, want 999", score_bcd);
    end
    step(0, 0, 1, 0);
    checks++;
    if (score_bcd !== 12'h999 || display_state !== 2'd1) begin
      errors++; $display("FAIL saturate: score %h disp %0d, want 999 disp 1", score_bcd, display_state);
    end
  endtask

  task automatic test_lives();
    logic [2:0] want [3];
    want[0] = 3'd2; want[1] = 3'd1; want[2] = 3'd0;
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      checks++;
      if (lives !== want[i]) begin
        errors++; $display("FAIL lives_dec%0d: lives %0d, want %0d", i, lives, want[i]);
      end
    end
    checks++;
    if (display_state !== 2'd3 || game_over !== 1'b1) begin
      errors++; $display("FAIL game_over: disp %0d over %b, want 3 1", display_state, game_over);
    end
    step(0, 0, 1, 0);
    checks++;
    if (score_bcd !== 12'h000 || lives !== 3'd0 || display_state !== 2'd3) begin
      errors++; $display("FAIL over_inc: score %h lives %0d disp %0d, want 000 0 3",
                         score_bcd, lives, display_state);
    end
  endtask

  task automatic test_simultaneous();
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    checks++;
    if (score_bcd !== 12'h005 || lives !== 3'd1 || display_state !== 2'd2) begin
      errors++; $display("FAIL inc_dec: score %h lives %0d disp %0d, want 005 1 2",
                         score_bcd, lives, display_state);
    end
    step(0, 1, 0, 1);
    checks++;
    if (score_bcd !== 12'h000 || lives !== 3'd3 || display_state !== 2'd0) begin
      errors++; $display("FAIL ng_dec: score %h lives %0d disp %0d, want 000 3 0",
                         score_bcd, lives, display_state);
    end
  endtask

  task automatic test_high_score();
    logic [11:0] want;
    @(negedge clock); reset = 1'b1; model_reset();
    @(negedge clock); reset = 1'b0;
    step(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    want = 12'h007;
`else
    want = 12'h000;
`endif
    checks++;
    if (best_bcd !== want) begin
      errors++; $display("FAIL best_game1: best %h, want %h", best_bcd, want);
    end
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    checks++;
    if (best_bcd !== want || game_over !== 1'b1) begin
      errors++; $display("FAIL best_game2: best %h over %b, want %h 1", best_bcd, game_over, want);
    end
  endtask

  task automatic test_random();
    logic t, ng, ip, dp;
    for (int n = 0; n < 3000; n++) begin
      t  = ($urandom_range(99) < 35);
      ng = ($urandom_range(199) < 3) || (m_mode == 4 && $urandom_range(9) == 0);
      ip = ($urandom_range(99) < 30);
      dp = ($urandom_range(99) < 6);
      step(t, ng, ip, dp);
      checks++;
      if (score_bcd !== to_bcd(m_score) || lives !== 3'(m_lives) || display_state !== exp_disp()
          || game_over !== (m_mode == 4) || best_bcd !== to_bcd(m_best)) begin
        errors++;
        $display("FAIL random[%0d]: score %h lives %0d disp %0d over %b best %h, want %h %0d %0d %b %h",
                 n, score_bcd, lives, display_state, game_over, best_bcd,
                 to_bcd(m_score), m_lives, exp_disp(), (m_mode == 4), to_bcd(m_best));
      end
    end
  endtask

  initial begin
    model_reset();
    #12;
    reset = 1'b0;
    #1;
    checks++;
    if (score_bcd !== 12'h000 || lives !== 3'd3 || display_state !== 2'd0 || game_over !== 1'b0
        || best_bcd !== 12'h000) begin
      errors++; $display("FAIL reset_state: score %h lives %0d disp %0d over %b best %h",
                         score_bcd, lives, display_state, game_over, best_bcd);
    end
    test_reset();
    test_hold();
    test_bcd_carry();
    test_lives();
    test_simultaneous();
    test_high_score();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
